// File: rtl/scalar_alu_pipe.sv
// scalar_alu_pipe: scalar ALU execute unit with per-wave SCC and valid/ready handshakes.
// Define SCALAR_ALU_MUL_EN to build the multi-cycle MUL_I32 path; otherwise MUL_I32 is illegal.
module scalar_alu_pipe #(
  parameter int DATA_W     = 32,
  parameter int NUM_WAVES  = 16,
  parameter int MUL_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_is_sopc,
  input  logic [7:0]                   in_opcode,
  input  logic [$clog2(NUM_WAVES)-1:0] in_wave,
  input  logic [6:0]                   in_sdst,
  input  logic [DATA_W-1:0]            in_src0,
  input  logic [DATA_W-1:0]            in_src1,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(NUM_WAVES)-1:0] out_wave,
  output logic [6:0]                   out_sdst,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_wr_en,
  output logic                         out_scc,
  output logic                         out_illegal,
  input  logic [$clog2(NUM_WAVES)-1:0] scc_rd_wave,
  output logic                         scc_rd_val
);
  localparam int WW = $clog2(NUM_WAVES);
  localparam int SW = $clog2(DATA_W);
  localparam int M  = DATA_W - 1;
  localparam logic [7:0] OP_ADD_U32 = 8'd0, OP_SUB_U32 = 8'd1, OP_ADD_I32 = 8'd2, OP_SUB_I32 = 8'd3;
  localparam logic [7:0] OP_ADDC_U32 = 8'd4, OP_SUBB_U32 = 8'd5, OP_MIN_I32 = 8'd6, OP_MIN_U32 = 8'd7;
  localparam logic [7:0] OP_MAX_I32 = 8'd8, OP_MAX_U32 = 8'd9, OP_CSELECT = 8'd10, OP_AND = 8'd14;
  localparam logic [7:0] OP_OR = 8'd16, OP_XOR = 8'd18, OP_LSHL = 8'd30, OP_LSHR = 8'd32;
  localparam logic [7:0] OP_ASHR = 8'd34, OP_MUL_I32 = 8'd38;

  logic [NUM_WAVES-1:0] r_scc;
  logic                 r_out_valid;
  logic [WW-1:0]        r_out_wave;
  logic [6:0]           r_out_sdst;
  logic [DATA_W-1:0]    r_out_data;
  logic                 r_out_wr_en, r_out_scc, r_out_illegal;

  logic              w_scc_in, w_free, w_acc, w_is_mul, w_load;
  logic [DATA_W:0]   w_add, w_sub;
  logic              w_add_ov, w_sub_ov, w_eq, w_slt, w_sgt, w_ult, w_ugt;
  logic [SW-1:0]     w_sh;
  logic [DATA_W-1:0] w_shl, w_shr, w_sar;
  logic [DATA_W-1:0] w_d, w_ld_data;
  logic              w_sc, w_wr, w_ill, w_ld_scc, w_ld_wr, w_ld_ill;
  logic [WW-1:0]     w_ld_wave;
  logic [6:0]        w_ld_sdst;

  assign scc_rd_val  = r_scc[scc_rd_wave];
  assign out_valid   = r_out_valid;
  assign out_wave    = r_out_wave;
  assign out_sdst    = r_out_sdst;
  assign out_data    = r_out_data;
  assign out_wr_en   = r_out_wr_en;
  assign out_scc     = r_out_scc;
  assign out_illegal = r_out_illegal;

  assign w_scc_in = r_scc[in_wave];
  assign w_free   = !r_out_valid || out_ready;
  assign w_acc    = in_valid && in_ready;
  assign w_is_mul = !in_is_sopc && in_opcode == OP_MUL_I32;

  assign w_add    = {1'b0, in_src0} + {1'b0, in_src1} + {{DATA_W{1'b0}}, in_opcode == OP_ADDC_U32 && w_scc_in};
  assign w_sub    = {1'b0, in_src0} - {1'b0, in_src1} - {{DATA_W{1'b0}}, in_opcode == OP_SUBB_U32 && w_scc_in};
  assign w_add_ov = (in_src0[M] == in_src1[M]) && (w_add[M] != in_src0[M]);
  assign w_sub_ov = (in_src0[M] != in_src1[M]) && (w_sub[M] != in_src0[M]);
  assign w_eq     = in_src0 == in_src1;
  assign w_slt    = $signed(in_src0) < $signed(in_src1);
  assign w_sgt    = $signed(in_src0) > $signed(in_src1);
  assign w_ult    = in_src0 < in_src1;
  assign w_ugt    = in_src0 > in_src1;
  assign w_sh     = in_src1[SW-1:0];
  assign w_shl    = in_src0 << w_sh;
  assign w_shr    = in_src0 >> w_sh;
  assign w_sar    = $signed(in_src0) >>> w_sh;

  always_comb begin
    w_d   = '0;
    w_sc  = w_scc_in;
    w_wr  = 1'b0;
    w_ill = 1'b0;
    if (in_is_sopc) begin
      case (in_opcode)
        8'd0:    w_sc = w_eq;
        8'd1:    w_sc = !w_eq;
        8'd2:    w_sc = w_sgt;
        8'd3:    w_sc = !w_slt;
        8'd4:    w_sc = w_slt;
        8'd5:    w_sc = !w_sgt;
        8'd6:    w_sc = w_eq;
        8'd7:    w_sc = !w_eq;
        8'd8:    w_sc = w_ugt;
        8'd9:    w_sc = !w_ult;
        8'd10:   w_sc = w_ult;
        8'd11:   w_sc = !w_ugt;
        default: w_ill = 1'b1;
      endcase
    end else begin
      w_wr = 1'b1;
      case (in_opcode)
        OP_ADD_U32, OP_ADDC_U32: {w_sc, w_d} = w_add;
        OP_SUB_U32, OP_SUBB_U32: {w_sc, w_d} = w_sub;
        OP_ADD_I32: begin w_d = w_add[M:0]; w_sc = w_add_ov; end
        OP_SUB_I32: begin w_d = w_sub[M:0]; w_sc = w_sub_ov; end
        OP_MIN_I32: begin w_d = w_slt ? in_src0 : in_src1; w_sc = w_slt; end
        OP_MIN_U32: begin w_d = w_ult ? in_src0 : in_src1; w_sc = w_ult; end
        OP_MAX_I32: begin w_d = w_sgt ? in_src0 : in_src1; w_sc = w_sgt; end
        OP_MAX_U32: begin w_d = w_ugt ? in_src0 : in_src1; w_sc = w_ugt; end
        OP_CSELECT: w_d = w_scc_in ? in_src0 : in_src1;
        OP_AND:     begin w_d = in_src0 & in_src1; w_sc = |(in_src0 & in_src1); end
        OP_OR:      begin w_d = in_src0 | in_src1; w_sc = |(in_src0 | in_src1); end
        OP_XOR:     begin w_d = in_src0 ^ in_src1; w_sc = |(in_src0 ^ in_src1); end
        OP_LSHL:    begin w_d = w_shl; w_sc = |w_shl; end
        OP_LSHR:    begin w_d = w_shr; w_sc = |w_shr; end
        OP_ASHR:    begin w_d = w_sar; w_sc = |w_sar; end
`ifdef SCALAR_ALU_MUL_EN
        OP_MUL_I32: w_wr = 1'b1;
`endif
        default:    begin w_wr = 1'b0; w_ill = 1'b1; end
      endcase
    end
  end

`ifdef SCALAR_ALU_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_t;
  localparam int CW = $clog2(MUL_CYCLES);
  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_m0, r_m1;
  logic [WW-1:0]     r_mwave;
  logic [6:0]        r_msdst;
  logic              w_mul_done;
  logic [DATA_W-1:0] w_prod;

  // Low product bits are identical for signed and unsigned operands.
  assign w_prod     = r_m0 * r_m1;
  assign w_mul_done = r_state == S_MUL && r_cnt == '0 && w_free;
  assign in_ready   = r_state == S_IDLE && w_free;
  assign w_load     = (w_acc && !w_is_mul) || w_mul_done;
  assign w_ld_wave  = w_mul_done ? r_mwave : in_wave;
  assign w_ld_sdst  = w_mul_done ? r_msdst : in_sdst;
  assign w_ld_data  = w_mul_done ? w_prod : w_d;
  assign w_ld_scc   = w_mul_done ? r_scc[r_mwave] : w_sc;
  assign w_ld_wr    = w_mul_done ? 1'b1 : w_wr;
  assign w_ld_ill   = w_mul_done ? 1'b0 : w_ill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_m0    <= '0;
      r_m1    <= '0;
      r_mwave <= '0;
      r_msdst <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_acc && w_is_mul) begin
        r_state <= S_MUL;
        r_cnt   <= CW'(MUL_CYCLES - 1);
        r_m0    <= in_src0;
        r_m1    <= in_src1;
        r_mwave <= in_wave;
        r_msdst <= in_sdst;
      end
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end else if (w_free) begin
      r_state <= S_IDLE;
    end
  end
`else
  assign in_ready  = w_free;
  assign w_load    = w_acc;
  assign w_ld_wave = in_wave;
  assign w_ld_sdst = in_sdst;
  assign w_ld_data = w_d;
  assign w_ld_scc  = w_sc;
  assign w_ld_wr   = w_wr;
  assign w_ld_ill  = w_ill;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scc         <= '0;
      r_out_valid   <= 1'b0;
      r_out_wave    <= '0;
      r_out_sdst    <= '0;
      r_out_data    <= '0;
      r_out_wr_en   <= 1'b0;
      r_out_scc     <= 1'b0;
      r_out_illegal <= 1'b0;
    end else if (w_load) begin
      r_scc[w_ld_wave] <= w_ld_scc;
      r_out_valid      <= 1'b1;
      r_out_wave       <= w_ld_wave;
      r_out_sdst       <= w_ld_sdst;
      r_out_data       <= w_ld_data;
      r_out_wr_en      <= w_ld_wr;
      r_out_scc        <= w_ld_scc;
      r_out_illegal    <= w_ld_ill;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_scalar_alu_pipe.sv
// tb_scalar_alu_pipe: directed vectors into a result scoreboard drained by an output monitor.
module tb_scalar_alu_pipe;
  typedef struct packed {
    logic [31:0] d;
    logic        scc;
    logic        wr;
    logic        ill;
    logic [3:0]  w;
    logic [6:0]  sd;
  } res_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_is_sopc = 1'b0;
  logic [7:0]  in_opcode = '0;
  logic [3:0]  in_wave = '0, out_wave, scc_rd_wave = '0;
  logic [6:0]  in_sdst = '0, out_sdst;
  logic [31:0] in_src0 = '0, in_src1 = '0, out_data;
  logic        out_valid, out_ready = 1'b1, out_wr_en, out_scc, out_illegal, scc_rd_val;

  res_t q[$];
  res_t act, held;
  logic stalled = 1'b0;
  int   compared = 0, mismatched = 0, n_out = 0;
  logic [6:0] sd_n = 7'd1;

  scalar_alu_pipe #(.DATA_W(32), .NUM_WAVES(16), .MUL_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_sopc(in_is_sopc), .in_opcode(in_opcode), .in_wave(in_wave), .in_sdst(in_sdst),
    .in_src0(in_src0), .in_src1(in_src1), .out_valid(out_valid), .out_ready(out_ready),
    .out_wave(out_wave), .out_sdst(out_sdst), .out_data(out_data), .out_wr_en(out_wr_en),
    .out_scc(out_scc), .out_illegal(out_illegal), .scc_rd_wave(scc_rd_wave), .scc_rd_val(scc_rd_val)
  );

  always #5 clk = ~clk;
  assign act = {out_data, out_scc, out_wr_en, out_illegal, out_wave, out_sdst};

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        compared++;
        if (act !== held) begin
          mismatched++;
          $display("FAIL hold: got %h expected %h", act, held);
        end
      end
      if (out_valid && !out_ready) begin
        compared++;
        if (in_ready !== 1'b0) begin
          mismatched++;
          $display("FAIL stall_in_ready: got %b expected 0", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        res_t e;
        compared++;
        n_out++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_result: got %h expected nothing", act);
        end else begin
          e = q.pop_front();
          if (act !== e) begin
            mismatched++;
            $display("FAIL result sdst=%0d: got %h expected %h", e.sd, act, e);
          end
        end
      end
      stalled = out_valid && !out_ready;
      held    = act;
    end
  end

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic send(input logic sopc, input logic [7:0] op, input logic [3:0] w,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] d, input logic scc, input logic wr, input logic ill);
    int n = 0;
    in_valid = 1'b1; in_is_sopc = sopc; in_opcode = op; in_wave = w;
    in_sdst = sd_n; in_src0 = a; in_src1 = b;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    compared++;
    if (!in_ready) begin
      mismatched++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 for sdst=%0d", sd_n);
    end else begin
      q.push_back({d, scc, wr, ill, w, sd_n});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sd_n = sd_n + 7'd1;
  endtask

  initial begin
    logic [15:0] sccs;
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {out_valid, in_ready, out_data, out_wr_en, out_scc, out_illegal, out_wave, out_sdst},
        {1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 7'h0});
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(0, 8'd0,  4'd3,  32'hFFFFFFFF, 32'h1, 32'h0, 1, 1, 0);
    send(0, 8'd4,  4'd3,  32'h0, 32'h0, 32'h1, 0, 1, 0);
    send(0, 8'd3,  4'd5,  32'h80000000, 32'h1, 32'h7FFFFFFF, 1, 1, 0);
    send(1, 8'd4,  4'd6,  32'hFFFFFFFF, 32'h0, 32'h0, 1, 0, 0);
    scc_rd_wave = 4'd6;
    #1;
    chk("scc_rd_wave6", {63'h0, scc_rd_val}, 64'h1);
    send(0, 8'd12, 4'd5,  32'h5, 32'h6, 32'h0, 1, 0, 1);
    send(0, 8'd34, 4'd7,  32'h80000000, 32'd31, 32'hFFFFFFFF, 1, 1, 0);
    send(0, 8'd6,  4'd8,  32'hFFFFFFFF, 32'h5, 32'hFFFFFFFF, 1, 1, 0);
    send(0, 8'd7,  4'd8,  32'h3, 32'h7, 32'h3, 1, 1, 0);
    send(0, 8'd9,  4'd8,  32'hFFFFFFFF, 32'h5, 32'hFFFFFFFF, 1, 1, 0);
    send(0, 8'd8,  4'd8,  32'h11, 32'h22, 32'h22, 0, 1, 0);
    send(0, 8'd10, 4'd8,  32'hAA, 32'hBB, 32'hBB, 0, 1, 0);
    send(0, 8'd1,  4'd9,  32'h1, 32'h2, 32'hFFFFFFFF, 1, 1, 0);
    send(0, 8'd5,  4'd9,  32'h5, 32'h1, 32'h3, 0, 1, 0);
    send(0, 8'd14, 4'd10, 32'hF0, 32'h0F, 32'h0, 0, 1, 0);
    send(0, 8'd16, 4'd10, 32'hF0, 32'h0F, 32'hFF, 1, 1, 0);
    send(0, 8'd18, 4'd10, 32'hFF, 32'hFF, 32'h0, 0, 1, 0);
    send(0, 8'd30, 4'd11, 32'h1, 32'h3F, 32'h80000000, 1, 1, 0);
    send(0, 8'd32, 4'd11, 32'h80000000, 32'h21, 32'h40000000, 1, 1, 0);
    send(0, 8'd2,  4'd12, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1, 1, 0);
    send(1, 8'd9,  4'd13, 32'h5, 32'h5, 32'h0, 1, 0, 0);
    send(1, 8'd0,  4'd13, 32'h1, 32'h2, 32'h0, 0, 0, 0);
    send(1, 8'd12, 4'd6,  32'h0, 32'h0, 32'h0, 1, 0, 1);
    send(0, 8'd10, 4'd6,  32'hAA, 32'hBB, 32'hAA, 1, 1, 0);
`ifdef SCALAR_ALU_MUL_EN
    send(0, 8'd38, 4'd6,  32'hFFFFFFFE, 32'h3, 32'hFFFFFFFA, 1, 1, 0);
    repeat (3) begin
      @(negedge clk);
      chk("mul_in_ready_low", {63'h0, in_ready}, 64'h0);
    end
`else
    send(0, 8'd38, 4'd6,  32'hFFFFFFFE, 32'h3, 32'h0, 1, 0, 1);
`endif
    n = 0;
    while (q.size() != 0 && n < 20) begin
      n++;
      @(posedge clk);
    end
    #1;
    out_ready = 1'b0;
    fork
      begin
        send(0, 8'd0,  4'd14, 32'h1, 32'h2, 32'h3, 0, 1, 0);
        send(0, 8'd0,  4'd14, 32'h4, 32'h5, 32'h9, 0, 1, 0);
        send(0, 8'd18, 4'd14, 32'h0, 32'h0, 32'h0, 0, 1, 0);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    @(posedge clk);
    #1;
`ifdef SCALAR_ALU_MUL_EN
    send(0, 8'd38, 4'd15, 32'h2, 32'h3, 32'h6, 0, 1, 0);
    @(posedge clk);
    #1;
`else
    out_ready = 1'b0;
    send(0, 8'd0, 4'd15, 32'h2, 32'h3, 32'h5, 0, 1, 0);
`endif
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("reset_mid_op", {62'h0, out_valid, in_ready}, 64'h1);
    for (int i = 0; i < 16; i++) begin
      scc_rd_wave = 4'(i);
      #0.1;
      sccs[i] = scc_rd_val;
    end
    chk("scc_cleared", {48'h0, sccs}, 64'h0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_out = 0;
    send(0, 8'd4, 4'd3, 32'hFFFFFFFF, 32'h2, 32'h1, 1, 1, 0);
    send(0, 8'd4, 4'd3, 32'h0, 32'h0, 32'h1, 0, 1, 0);
    n = 0;
    while (q.size() != 0 && n < 20) begin
      n++;
      @(posedge clk);
    end
    @(negedge clk);
    chk("drain_after_reset", {32'(q.size()), 32'(n_out)}, {32'h0, 32'h2});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
